// File: rtl/universal_shift_reg_n.sv
// Universal shift register: hold, shifts, rotates, arithmetic shift, load, plus multi-step burst.
// Latency: single ops take effect at the next edge; a burst of k steps completes k edges after acceptance.
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    logic [2:0]       mode_lat;
    logic [AMT_W-1:0] count;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic             step_mode;

    // While busy the latched burst mode drives the datapath; live mode is ignored.
    always_comb begin
        op_mode = busy ? mode_lat : mode;
        q_nxt   = q;
        so_nxt  = ser_out;
        case (op_mode)
            M_SHR:  begin q_nxt = {ser_in_r, q[WIDTH-1:1]};   so_nxt = q[0];       end
            M_SHL:  begin q_nxt = {q[WIDTH-2:0], ser_in_l};   so_nxt = q[WIDTH-1]; end
            M_LOAD: begin q_nxt = par_in;                                          end
            M_ROR:  begin q_nxt = {q[0], q[WIDTH-1:1]};       so_nxt = q[0];       end
            M_ROL:  begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; so_nxt = q[WIDTH-1]; end
            M_ASR:  begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; so_nxt = q[0];       end
            default: ;
        endcase
    end

    always_comb begin
        step_mode = (mode == M_SHR) || (mode == M_SHL) || (mode == M_ROR) ||
                    (mode == M_ROL) || (mode == M_ASR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            ser_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            mode_lat <= 3'b000;
        end else begin
            done <= 1'b0;
            if (busy) begin
                q       <= q_nxt;
                ser_out <= so_nxt;
                count   <= count - AMT_W'(1);
                if (count == AMT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start && step_mode) begin
                // Acceptance edge: latch only, q is untouched until the first step.
                mode_lat <= mode;
                count    <= amt;
                if (amt == '0) begin
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end else if (en) begin
                q       <= q_nxt;
                ser_out <= so_nxt;
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Bench for universal_shift_reg_n: directed scenarios then random ops against an arithmetic model.
module tb_universal_shift_reg_n;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;
    localparam int MSB_WEIGHT = 2 ** (W - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic          ser_in_r;
    logic          ser_in_l;
    logic [W-1:0]  par_in;
    logic          start;
    logic [AW-1:0] amt;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;

    universal_shift_reg_n #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .par_in(par_in),
        .start(start), .amt(amt),
        .q(q), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: register value, last bit out, and a queue of pending burst steps.
    logic [W-1:0] m_q;
    logic         m_so;
    logic         m_done;
    logic [2:0]   pend[$];

    function automatic bit is_step(input logic [2:0] m);
        return m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5 || m == 3'd6;
    endfunction

    task automatic apply(input logic [2:0] m, input logic sr, input logic sl, input logic [W-1:0] p);
        int v;
        int r;
        v = int'(m_q);
        r = v;
        case (m)
            3'd1: begin r = v / 2 + (sr ? MSB_WEIGHT : 0);                  m_so = (v % 2) != 0;          end
            3'd2: begin r = (v * 2) % (2 * MSB_WEIGHT) + (sl ? 1 : 0);      m_so = v >= MSB_WEIGHT;       end
            3'd3: begin r = int'(p);                                                                      end
            3'd4: begin r = v / 2 + (v % 2) * MSB_WEIGHT;                   m_so = (v % 2) != 0;          end
            3'd5: begin r = (v * 2) % (2 * MSB_WEIGHT) + v / MSB_WEIGHT;    m_so = v >= MSB_WEIGHT;       end
            3'd6: begin r = v / 2 + (v >= MSB_WEIGHT ? MSB_WEIGHT : 0);     m_so = (v % 2) != 0;          end
            default: ;
        endcase
        m_q = W'(r);
    endtask

    task automatic model_step(input logic e, input logic [2:0] m, input logic sr, input logic sl,
                              input logic [W-1:0] p, input logic s, input logic [AW-1:0] a);
        m_done = 1'b0;
        if (pend.size() > 0) begin
            apply(pend.pop_front(), sr, sl, p);
            if (pend.size() == 0) m_done = 1'b1;
        end else if (s && is_step(m)) begin
            if (a == 0) m_done = 1'b1;
            else for (int i = 0; i < int'(a); i++) pend.push_back(m);
        end else if (e) begin
            apply(m, sr, sl, p);
        end
    endtask

    task automatic model_reset();
        m_q = '0;
        m_so = 1'b0;
        m_done = 1'b0;
        pend.delete();
    endtask

    // Drive one cycle at the falling edge, advance the model, then compare at the next falling edge.
    task automatic op(input string tag, input logic e, input logic [2:0] m, input logic sr,
                      input logic sl, input logic [W-1:0] p, input logic s, input logic [AW-1:0] a);
        en = e; mode = m; ser_in_r = sr; ser_in_l = sl; par_in = p; start = s; amt = a;
        model_step(e, m, sr, sl, p, s, a);
        @(negedge clk);
        check({tag, "/q"},       32'(q),       32'(m_q));
        check({tag, "/ser_out"}, 32'(ser_out), 32'(m_so));
        check({tag, "/busy"},    32'(busy),    32'(pend.size() > 0));
        check({tag, "/done"},    32'(done),    32'(m_done));
    endtask

    task automatic idle(input string tag);
        op(tag, 1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; ser_in_r = 1'b0; ser_in_l = 1'b0;
        par_in = '0; start = 1'b0; amt = '0;
        model_reset();
        #1;
        check("reset/q", 32'(q), 32'h0);
        check("reset/ser_out", 32'(ser_out), 32'h0);
        check("reset/busy", 32'(busy), 32'h0);
        check("reset/done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle load, shift right, shift left.
        op("load_b4", 1'b1, 3'd3, 1'b0, 1'b0, 8'hB4, 1'b0, '0);
        check("load_b4/const", 32'(q), 32'hB4);
        op("shr", 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, '0);
        check("shr/const", 32'(q), 32'hDA);
        check("shr/so_const", 32'(ser_out), 32'h0);
        op("shl", 1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, '0);
        check("shl/const", 32'(q), 32'hB4);
        check("shl/so_const", 32'(ser_out), 32'h1);

        // Rotate-left burst of 3 on 0x81.
        op("load_81", 1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 1'b0, '0);
        op("rol_accept", 1'b0, 3'd5, 1'b0, 1'b0, '0, 1'b1, AW'(3));
        check("rol_accept/q_const", 32'(q), 32'h81);
        idle("rol_s1");
        check("rol_s1/const", 32'(q), 32'h03);
        idle("rol_s2");
        check("rol_s2/const", 32'(q), 32'h06);
        idle("rol_s3");
        check("rol_s3/const", 32'(q), 32'h0C);
        check("rol_s3/done_const", 32'(done), 32'h1);
        idle("rol_after");

        // Arithmetic-shift burst with the ignored inputs toggling underneath.
        op("load_90", 1'b1, 3'd3, 1'b0, 1'b0, 8'h90, 1'b0, '0);
        op("asr_accept", 1'b0, 3'd6, 1'b0, 1'b0, '0, 1'b1, AW'(2));
        op("asr_s1", 1'b1, 3'd3, 1'b1, 1'b1, 8'h55, 1'b0, '0);
        check("asr_s1/const", 32'(q), 32'hC8);
        op("asr_s2", 1'b0, 3'd2, 1'b0, 1'b1, 8'hAA, 1'b0, '0);
        check("asr_s2/const", 32'(q), 32'hE4);
        idle("asr_after");

        // Zero-length burst, then a 5-step burst with start held the whole time.
        op("amt0", 1'b0, 3'd1, 1'b0, 1'b0, '0, 1'b1, AW'(0));
        check("amt0/done_const", 32'(done), 32'h1);
        op("b5_accept", 1'b0, 3'd4, 1'b0, 1'b0, '0, 1'b1, AW'(5));
        for (int i = 0; i < 5; i++) op("b5_step", 1'b1, 3'd1, 1'b1, 1'b0, 8'h77, 1'b1, AW'(2));
        check("b5_end/done_const", 32'(done), 32'h1);
        idle("b5_after");

        // Reset arrives asynchronously in the middle of a burst.
        op("load_ff", 1'b1, 3'd3, 1'b0, 1'b0, 8'hFF, 1'b0, '0);
        op("shr6_accept", 1'b0, 3'd1, 1'b0, 1'b0, '0, 1'b1, AW'(6));
        idle("shr6_s1");
        idle("shr6_s2");
        check("shr6_s2/const", 32'(q), 32'h3F);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst/q", 32'(q), 32'h0);
        check("arst/busy", 32'(busy), 32'h0);
        check("arst/done", 32'(done), 32'h0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) idle("post_rst");

        // Reserved mode holds; start with load mode is just a load.
        op("load_5a", 1'b1, 3'd3, 1'b0, 1'b0, 8'h5A, 1'b0, '0);
        op("mode7", 1'b1, 3'd7, 1'b1, 1'b1, 8'h11, 1'b0, '0);
        check("mode7/const", 32'(q), 32'h5A);
        op("start_load", 1'b1, 3'd3, 1'b0, 1'b0, 8'h3C, 1'b1, AW'(4));
        check("start_load/const", 32'(q), 32'h3C);
        check("start_load/busy_const", 32'(busy), 32'h0);

        for (int i = 0; i < 500; i++) begin
            op("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
               ($urandom_range(0, 5) == 0), AW'($urandom_range(0, 11)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg_n.md
Name: universal_shift_reg_n

Overview:
Parametrised universal shift register. It supports hold, logical shift right and left, rotate right and left, arithmetic shift right, and parallel load. It adds a multi-step "burst" mode that performs a programmable number of single-bit steps with a busy/done handshake. It is the WIDTH-generic successor of the 4-bit universal register and is used for serialisers, bit-aligners and shift-based arithmetic in datapaths.

Parameters:
WIDTH, 8, register width in bits (≥2)
AMT_W, $clog2(WIDTH)+1, width of burst step count (derived; may be overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  single-cycle operation enable (ignored while busy)
mode  in  3  operation select (see Behaviour)
ser_in_r  in  1  serial input entering MSB on right shift
ser_in_l  in  1  serial input entering LSB on left shift
par_in  in  WIDTH  parallel load data
start  in  1  request burst of amt steps of current mode
amt  in  AMT_W  burst step count
q  out  WIDTH  register contents
ser_out  out  1  last bit shifted/rotated out (registered)
busy  out  1  burst in progress
done  out  1  one-cycle pulse, burst complete

Behaviour:
- Decided: reset rst, asynchronous, active-high; clock clk. On rst: q=0, ser_out=0, busy=0, done=0, internal count=0, latched mode=000. Reset mid-burst aborts the burst; no done pulse is produced.
- Mode encoding:
  - 000 hold.
  - 001 shift right: q<={ser_in_r,q[W-1:1]}, ser_out<=q[0].
  - 010 shift left: q<={q[W-2:0],ser_in_l}, ser_out<=q[W-1].
  - 011 parallel load: q<=par_in; ser_out unchanged.
  - 100 rotate right: ser_out<=q[0].
  - 101 rotate left: ser_out<=q[W-1].
  - 110 arithmetic shift right: MSB replicated, ser_out<=q[0].
  - 111 reserved, behaves as hold.
- Step modes are 001, 010, 100, 101 and 110. Hold/load/reserved modes never change ser_out.
- Single-cycle op: busy=0, start=0, en=1 → the mode is applied at the next rising edge (1-cycle latency). With en=0, q and ser_out hold.
- Burst acceptance: busy=0, start=1, mode is a step mode → at edge E0, latch mode and amt; q is unchanged at E0.
  - amt≥1: busy<=1, count<=amt.
  - amt=0: busy stays 0, done<=1 at E0 (pulse in the following cycle), q unchanged.
- Burst execution: edges E1..Ek (k=amt) each apply one step of the latched mode.
  - ser_in_r and ser_in_l are sampled live at each step edge.
  - count decrements on every step.
  - At Ek: busy<=0, done<=1. done is high for exactly one cycle after Ek.
  - busy is high from after E0 through Ek (k cycles).
- Precedence: start takes priority over en when both are high. A start with a non-step mode is not a burst; it behaves as a single-cycle op if en=1 and is ignored otherwise.
- While busy=1: en, mode, start, amt and par_in are ignored; start is not queued.
- Back-to-back bursts: start may be asserted in the cycle done is high (busy=0) and is accepted.
- amt>WIDTH is legal and executes literally (shifts fill fully with serial/sign bits; rotates wrap).
- done and busy are never both high.

Test Plan:
- WIDTH=8, reset → 1-cycle load par_in=0xB4 → q=0xB4, ser_out=0. Then shift right, ser_in_r=1 → q=0xDA, ser_out=0. Then shift left, ser_in_l=0 → q=0xB4, ser_out=1.
- q=0x81, start, mode=101, amt=3 → busy high 3 cycles, q sequence 0x03, 0x06, 0x0C, done pulse 1 cycle after last step, final ser_out=0.
- q=0x90, start, mode=110, amt=2 → q=0xC8 then 0xE4, done pulse, busy low. During the burst, toggle en/mode/par_in → no effect.
- start with amt=0 → done pulses once, busy stays 0, q unchanged. Assert start again while a burst with amt=5 is running → ignored; exactly 5 steps, one done.
- Burst mode=001, amt=6 on q=0xFF, ser_in_r=0; assert rst asynchronously after step 2 → q=0, busy=0, done=0 immediately; no done pulse afterwards.
- mode=111 with en=1, and start with mode=011 → q unchanged for 111; load occurs for 011 with en=1, busy never asserts.
